// File: rtl/kogge_stone_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake and global stall.
// Optional signed-overflow output ovf is enabled by defining KSA_OVERFLOW_EN.
module kogge_stone_pipe_adder #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef KSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned NGRP   = (LEVELS + REG_EVERY - 1) / REG_EVERY;

  // Applies the prefix levels that belong to register group grp.
  function automatic void prefix_group(input logic [WIDTH-1:0] g_in,
                                       input logic [WIDTH-1:0] p_in,
                                       input int unsigned grp,
                                       output logic [WIDTH-1:0] g_out,
                                       output logic [WIDTH-1:0] p_out);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] lo;
    g = g_in;
    p = p_in;
    for (int unsigned k = 0; k < LEVELS; k++) begin
      if (k / REG_EVERY == grp) begin
        lo = (WIDTH'(1) << (1 << k)) - WIDTH'(1);
        g  = g | (p & (g << (1 << k)));
        p  = p & ((p << (1 << k)) | lo);
      end
    end
    g_out = g;
    p_out = p;
  endfunction

  logic [WIDTH-1:0] g_q  [NGRP];
  logic [WIDTH-1:0] g_d  [NGRP];
  logic [WIDTH-1:0] p_q  [NGRP];
  logic [WIDTH-1:0] p_d  [NGRP];
  logic [WIDTH-1:0] po_q [NGRP];
  logic [WIDTH-1:0] po_d [NGRP];
  logic             c0_q [NGRP];
  logic             c0_d [NGRP];
  logic             v_q  [NGRP];
  logic             v_d  [NGRP];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef KSA_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic             adv;
  logic [WIDTH-1:0] b_eff, g0, p0, gt, pt;
  logic             c0;

  assign adv       = out_ready || !out_valid_q;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef KSA_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

  // Next-state for every stage; everything holds unless the pipe advances.
  always_comb begin
    g_d         = g_q;
    p_d         = p_q;
    po_d        = po_q;
    c0_d        = c0_q;
    v_d         = v_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
`ifdef KSA_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif
    gt          = '0;
    pt          = '0;
    b_eff       = sub ? ~b : b;
    c0          = sub ? 1'b1 : cin;
    g0          = a & b_eff;
    p0          = a ^ b_eff;
    if (adv) begin
      // Carry-in folded into bit 0 generate so G[i] is the true carry out of bit i.
      v_d[0]  = in_valid;
      g_d[0]  = {g0[WIDTH-1:1], g0[0] | (p0[0] & c0)};
      p_d[0]  = p0;
      po_d[0] = p0;
      c0_d[0] = c0;
      for (int unsigned j = 1; j < NGRP; j++) begin
        prefix_group(g_q[j-1], p_q[j-1], j - 1, gt, pt);
        g_d[j]  = gt;
        p_d[j]  = pt;
        po_d[j] = po_q[j-1];
        c0_d[j] = c0_q[j-1];
        v_d[j]  = v_q[j-1];
      end
      prefix_group(g_q[NGRP-1], p_q[NGRP-1], NGRP - 1, gt, pt);
      out_valid_d = v_q[NGRP-1];
      if (v_q[NGRP-1]) begin
        sum_d  = po_q[NGRP-1] ^ {gt[WIDTH-2:0], c0_q[NGRP-1]};
        cout_d = gt[WIDTH-1];
`ifdef KSA_OVERFLOW_EN
        ovf_d  = gt[WIDTH-2] ^ gt[WIDTH-1];
`endif
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < NGRP; j++) begin
        g_q[j]  <= '0;
        p_q[j]  <= '0;
        po_q[j] <= '0;
        c0_q[j] <= 1'b0;
        v_q[j]  <= 1'b0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef KSA_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      g_q         <= g_d;
      p_q         <= p_d;
      po_q        <= po_d;
      c0_q        <= c0_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
`ifdef KSA_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_kogge_stone_pipe_adder.sv
// Scoreboard bench for kogge_stone_pipe_adder: a 16-bit/REG_EVERY=2 and a 4-bit/REG_EVERY=1 instance.
module tb_kogge_stone_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv16, ir16, cin16, sub16, ov16, or16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        iv4, ir4, cin4, sub4, ov4, or4, cout4;
  logic [3:0]  a4, b4, sum4;
`ifdef KSA_OVERFLOW_EN
  logic        ovf16, ovf4;
`endif

  kogge_stone_pipe_adder #(.WIDTH(16), .REG_EVERY(2)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16)
`ifdef KSA_OVERFLOW_EN
    , .ovf(ovf16)
`endif
  );

  kogge_stone_pipe_adder #(.WIDTH(4), .REG_EVERY(1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4)
`ifdef KSA_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Pops and checks a result whenever either DUT completes an output transfer.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ov16 && !or16 && q16.size() > 0) chk("stall_sum16", 32'(sum16), 32'(q16[0].s));
        if (ov16 && or16) begin
          if (q16.size() == 0) chk("unexpected16", 32'(ov16), 32'd0);
          else begin
            e = q16.pop_front();
            chk("sum16", 32'(sum16), 32'(e.s));
            chk("cout16", 32'(cout16), 32'(e.c));
`ifdef KSA_OVERFLOW_EN
            chk("ovf16", 32'(ovf16), 32'(e.o));
`endif
            if (e.lat) chk("latency16", 32'(cyc - e.acc), 32'd3);
          end
        end
        if (ov4 && or4) begin
          if (q4.size() == 0) chk("unexpected4", 32'(ov4), 32'd0);
          else begin
            e = q4.pop_front();
            chk("sum4", 32'(sum4), 32'(e.s));
            chk("cout4", 32'(cout4), 32'(e.c));
`ifdef KSA_OVERFLOW_EN
            chk("ovf4", 32'(ovf4), 32'(e.o));
`endif
            if (e.lat) chk("latency4", 32'(cyc - e.acc), 32'd3);
          end
        end
      end
    end
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic su,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input bit push, input bit lat);
    int   n;
    exp_t e;
    a16 = a; b16 = b; cin16 = ci; sub16 = su; iv16 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ir16 && n < 100);
    if (!ir16) begin
      chk("accept16_timeout", 32'(ir16), 32'd1);
      iv16 = 1'b0;
      return;
    end
    e.s = es; e.c = ec; e.o = eo; e.acc = cyc; e.lat = lat;
    @(posedge clk);
    #1;
    if (push) q16.push_back(e);
    iv16 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic su,
                       input logic [3:0] es, input logic ec, input logic eo);
    int   n;
    exp_t e;
    a4 = a; b4 = b; cin4 = ci; sub4 = su; iv4 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ir4 && n < 100);
    if (!ir4) begin
      chk("accept4_timeout", 32'(ir4), 32'd1);
      iv4 = 1'b0;
      return;
    end
    e.s = 16'(es); e.c = ec; e.o = eo; e.acc = cyc; e.lat = 1'b1;
    @(posedge clk);
    #1;
    q4.push_back(e);
    iv4 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q16.size() != 0 || q4.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (q16.size() != 0 || q4.size() != 0) chk("drain_timeout", 32'(q16.size() + q4.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
    iv4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0; sub4  = 1'b0; or4  = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    #12;
    chk("rst_out_valid16", 32'(ov16), 32'd0);
    chk("rst_sum16", 32'(sum16), 32'd0);
    chk("rst_cout16", 32'(cout16), 32'd0);
    chk("rst_out_valid4", 32'(ov4), 32'd0);
`ifdef KSA_OVERFLOW_EN
    chk("rst_ovf16", 32'(ovf16), 32'd0);
`endif
    #5 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready16", 32'(ir16), 32'd1);
    chk("rst_in_ready4", 32'(ir4), 32'd1);
    @(posedge clk);
    #1;

    // 4-bit, one register per prefix level
    send4(4'b1101, 4'b1011, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0);
    send4(4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
    send4(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
    send4(4'b0011, 4'b0101, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0);
    send4(4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);
    drain();

    // 16-bit back-to-back stream
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    send16(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Subtraction, cin ignored, equal operands
    send16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b1);
    send16(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1);
    send16(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

`ifdef KSA_OVERFLOW_EN
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
    send16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b1);
    send16(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
`endif

    // Backpressure: 5 stalled cycles while offering 4 operand pairs
    or16 = 1'b0;
    fork
      begin
        send16(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b1, 1'b0);
        send16(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        send16(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        send16(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00FE, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready16", 32'(ir16), 32'd0);
        chk("stall_out_valid16", 32'(ov16), 32'd1);
        @(posedge clk);
        #1 or16 = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with operations in flight
    send16(16'hF000, 16'h2000, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0);
    send16(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0);
    send16(16'h4444, 16'h1111, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid16", 32'(ov16), 32'd0);
    chk("midrst_sum16", 32'(sum16), 32'd0);
    chk("midrst_cout16", 32'(cout16), 32'd0);
`ifdef KSA_OVERFLOW_EN
    chk("midrst_ovf16", 32'(ovf16), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready16", 32'(ir16), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale16", 32'(ov16), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
